// File: rtl/traffic_light_renderer.sv
// Pixel stage behind the 640x480 VGA timing generator: frame-timed traffic-light
// phase FSM and a 2-cycle pipeline that paints the signal head as 12-bit RGB.
module traffic_light_renderer #(
  parameter int RED_FRAMES        = 300,
  parameter int RED_YELLOW_FRAMES = 60,
  parameter int GREEN_FRAMES      = 300,
  parameter int YELLOW_FRAMES     = 90,
  parameter int LAMP_X            = 288,
  parameter int LAMP_Y0           = 96,
  parameter int LAMP_SIZE         = 64,
  parameter int LAMP_GAP          = 32,
  parameter int HOUSING_MARGIN    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hold,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [11:0] rgb,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    RED        = 2'd0,
    RED_YELLOW = 2'd1,
    GREEN      = 2'd2,
    YELLOW     = 2'd3
  } phase_t;

  localparam int CW = 16;
  localparam logic [10:0] HX0 = 11'(LAMP_X - HOUSING_MARGIN);
  localparam logic [10:0] HX1 = 11'(LAMP_X + LAMP_SIZE + HOUSING_MARGIN);
  localparam logic [10:0] HY0 = 11'(LAMP_Y0 - HOUSING_MARGIN);
  localparam logic [10:0] HY1 = 11'(LAMP_Y0 + 3*LAMP_SIZE + 2*LAMP_GAP + HOUSING_MARGIN);
  localparam logic [10:0] LX0 = 11'(LAMP_X);
  localparam logic [10:0] LX1 = 11'(LAMP_X + LAMP_SIZE);

  phase_t          r_phase;
  logic [CW-1:0]   r_cnt;
  logic            r_vs_prev;
  logic [CW-1:0]   w_dur_m1;
  logic            w_tick;

  logic            r_s1_hs, r_s1_vs, r_s1_vo, r_s1_house;
  logic [2:0]      r_s1_lamp;
  logic            r_hs, r_vs;
  logic [11:0]     r_rgb;

  logic [10:0]     w_x, w_y;
  logic            w_vo, w_house, w_inx;
  logic [2:0]      w_lamp;
  logic [11:0]     w_rgb;

  // Frame tick on the first cycle of vsync; edge register resets high so a
  // vsync already asserted at reset release does not count as a frame.
  assign w_tick = vsync_in & ~r_vs_prev;

  always_comb begin
    w_dur_m1 = '0;
    case (r_phase)
      RED:        w_dur_m1 = CW'(RED_FRAMES - 1);
      RED_YELLOW: w_dur_m1 = CW'(RED_YELLOW_FRAMES - 1);
      GREEN:      w_dur_m1 = CW'(GREEN_FRAMES - 1);
      YELLOW:     w_dur_m1 = CW'(YELLOW_FRAMES - 1);
      default:    w_dur_m1 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= RED;
      r_cnt     <= '0;
      r_vs_prev <= 1'b1;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_tick && !hold) begin
        if (r_cnt == w_dur_m1) begin
          r_cnt <= '0;
          case (r_phase)
            RED:        r_phase <= RED_YELLOW;
            RED_YELLOW: r_phase <= GREEN;
            GREEN:      r_phase <= YELLOW;
            default:    r_phase <= RED;
          endcase
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign phase = r_phase;

  // Hit tests at 11 bits so bound arithmetic cannot wrap.
  always_comb begin
    w_x     = {1'b0, x};
    w_y     = {1'b0, y};
    w_vo    = video_on && (x < 10'd640) && (y < 10'd480);
    w_house = (w_x >= HX0) && (w_x < HX1) && (w_y >= HY0) && (w_y < HY1);
    w_inx   = (w_x >= LX0) && (w_x < LX1);
    for (int k = 0; k < 3; k++)
      w_lamp[k] = w_inx
                && (w_y >= 11'(LAMP_Y0 + k*(LAMP_SIZE + LAMP_GAP)))
                && (w_y <  11'(LAMP_Y0 + k*(LAMP_SIZE + LAMP_GAP) + LAMP_SIZE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_vo    <= 1'b0;
      r_s1_house <= 1'b0;
      r_s1_lamp  <= '0;
    end else begin
      r_s1_hs    <= hsync_in;
      r_s1_vs    <= vsync_in;
      r_s1_vo    <= w_vo;
      r_s1_house <= w_house;
      r_s1_lamp  <= w_lamp;
    end
  end

  // Lamps sit inside the housing, so they take priority over the housing grey.
  always_comb begin
    w_rgb = 12'h000;
    if (!r_s1_vo)
      w_rgb = 12'h000;
    else if (r_s1_lamp[0])
      w_rgb = (r_phase == RED || r_phase == RED_YELLOW) ? 12'hF00 : 12'h400;
    else if (r_s1_lamp[1])
      w_rgb = (r_phase == RED_YELLOW || r_phase == YELLOW) ? 12'hFF0 : 12'h440;
    else if (r_s1_lamp[2])
      w_rgb = (r_phase == GREEN) ? 12'h0F0 : 12'h040;
    else if (r_s1_house)
      w_rgb = 12'h333;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= 12'h000;
    end else begin
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
      r_rgb <= w_rgb;
    end
  end

  assign hsync_out = r_hs;
  assign vsync_out = r_vs;
  assign rgb       = r_rgb;

endmodule

// File: tb/tb_traffic_light_renderer.sv
// Randomized self-checking bench for traffic_light_renderer against a
// frame-count / geometry reference model (short phase durations).
module tb_traffic_light_renderer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b0, vsync_in = 1'b1, video_on = 1'b0, hold = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        hsync_out, vsync_out;
  logic [11:0] rgb;
  logic [1:0]  phase;

  int checks = 0;
  int errors = 0;
  int m_ticks = 0;

  traffic_light_renderer #(
    .RED_FRAMES(2), .RED_YELLOW_FRAMES(1), .GREEN_FRAMES(3), .YELLOW_FRAMES(1)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on(video_on), .x(x), .y(y), .hold(hold),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb(rgb), .phase(phase)
  );

  always #5 clk = ~clk;

  // Phase from number of counted frames: 2 RED, 1 RED_YELLOW, 3 GREEN, 1 YELLOW.
  function automatic int ref_phase(int t);
    int m;
    m = t % 7;
    if (m < 2) return 0;
    if (m < 3) return 1;
    if (m < 6) return 2;
    return 3;
  endfunction

  function automatic logic [11:0] ref_rgb(int px, int py, bit vo, int ph);
    int rel, k;
    if (!vo || px > 639 || py > 479) return 12'h000;
    if (px >= 288 && px < 352 && py >= 96 && py < 352) begin
      rel = py - 96;
      k = rel / 96;
      if (rel % 96 < 64) begin
        if (k == 0) return (ph == 0 || ph == 1) ? 12'hF00 : 12'h400;
        if (k == 1) return (ph == 1 || ph == 3) ? 12'hFF0 : 12'h440;
        return (ph == 2) ? 12'h0F0 : 12'h040;
      end
    end
    if (px >= 272 && px < 368 && py >= 80 && py < 368) return 12'h333;
    return 12'h000;
  endfunction

  task automatic do_reset(bit vs_level);
    @(negedge clk);
    rst = 1'b1; vsync_in = vs_level; hold = 1'b0;
    hsync_in = 1'b0; video_on = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_ticks = 0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk); vsync_in = 1'b1;
    @(negedge clk); @(negedge clk); vsync_in = 1'b0;
    @(negedge clk);
    if (!hold) m_ticks++;
    checks++;
    if (phase !== 2'(ref_phase(m_ticks))) begin
      errors++;
      $display("FAIL phase_after_tick%0d got %0d exp %0d", m_ticks, phase, ref_phase(m_ticks));
    end
  endtask

  task automatic probe(string name, int px, int py, bit vo);
    logic [11:0] e;
    @(negedge clk);
    x = 10'(px); y = 10'(py); video_on = vo;
    @(negedge clk); @(negedge clk);
    e = ref_rgb(px, py, vo, ref_phase(m_ticks));
    checks++;
    if (rgb !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, rgb, e);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    pulse_vsync(); pulse_vsync();
    @(negedge clk);
    x = 10'd300; y = 10'd100; video_on = 1'b1; hsync_in = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; vsync_in = 1'b1;
    #1;
    checks++;
    if (rgb !== 12'h000 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_async got rgb=%h hs=%b vs=%b ph=%0d exp 000/0/0/0",
               rgb, hsync_out, vsync_out, phase);
    end
    @(negedge clk);
    rst = 1'b0; hsync_in = 1'b0; video_on = 1'b0; m_ticks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (phase !== 2'd0) begin
        errors++;
        $display("FAIL reset_vsync_high got %0d exp 0", phase);
      end
    end
    vsync_in = 1'b0;
    pulse_vsync();
  endtask

  task automatic test_phase_timing();
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) pulse_vsync();
  endtask

  task automatic test_hold();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) pulse_vsync();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) pulse_vsync();
    hold = 1'b0;
    for (int i = 0; i < 3; i++) pulse_vsync();
  endtask

  task automatic test_latency();
    logic       exp_hs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] exp_c [5] = '{12'h000, 12'h000, 12'hF00, 12'h000, 12'h000};
    do_reset(1'b0);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rgb !== exp_c[i] || hsync_out !== exp_hs[i]) begin
          errors++;
          $display("FAIL latency_c%0d got rgb=%h hs=%b exp rgb=%h hs=%b",
                   i, rgb, hsync_out, exp_c[i], exp_hs[i]);
        end
      end
      x = 10'd300; y = 10'd100;
      video_on = (i == 0);
      hsync_in = (i < 2);
    end
  endtask

  task automatic test_colour_map();
    do_reset(1'b0);
    probe("red_lamp_edge_x351", 351, 96, 1'b1);
    probe("housing_x352",       352, 96, 1'b1);
    probe("housing_x367",       367, 96, 1'b1);
    probe("outside_x368",       368, 96, 1'b1);
    probe("lamp_y159",          300, 159, 1'b1);
    probe("gap_y160",           300, 160, 1'b1);
    for (int i = 0; i < 3; i++) pulse_vsync();
    probe("green_red_off",      300, 100, 1'b1);
    probe("green_yel_off",      300, 200, 1'b1);
    probe("green_on",           300, 300, 1'b1);
    probe("green_housing",      280, 85,  1'b1);
    probe("green_bg",           10,  10,  1'b1);
    probe("green_blank",        300, 100, 1'b0);
  endtask

  task automatic test_random_stream();
    logic [12:0] q[$];
    logic [12:0] e;
    int px, py, ph;
    bit vo, hs;
    do_reset(1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int p = $urandom_range(0, 6); p > 0; p--) pulse_vsync();
      ph = ref_phase(m_ticks);
      q.delete();
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (q.size() == 2) begin
          e = q.pop_front();
          checks++;
          if ({hsync_out, rgb} !== e || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL random_r%0d_i%0d got hs=%b vs=%b rgb=%h exp hs=%b vs=0 rgb=%h",
                     r, i, hsync_out, vsync_out, rgb, e[12], e[11:0]);
          end
        end
        if ($urandom_range(0, 3) == 0) begin
          px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
        end else begin
          px = $urandom_range(260, 380); py = $urandom_range(70, 380);
        end
        vo = ($urandom_range(0, 7) != 0);
        hs = $urandom_range(0, 1);
        x = 10'(px); y = 10'(py); video_on = vo; hsync_in = hs;
        q.push_back({hs, ref_rgb(px, py, vo, ph)});
      end
      @(negedge clk);
      hsync_in = 1'b0; video_on = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_colour_map();
    test_phase_timing();
    test_hold();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
